// File: rtl/bw_game_ctrl_pkg.sv
// Shared definitions for the black-and-white tile game controller.
// Holds the display state codes, verdict encodings and tile-bank constants
// used by the controller, the tile banks and anything decoding the status bus.
package bw_game_ctrl_pkg;

    // Display state codes; 3'b111 is deliberately left out and recovers to INIT.
    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_RASP     = 3'b001,
        ST_BAWP     = 3'b010,
        ST_P1_TURN  = 3'b011,
        ST_P2_TURN  = 3'b100,
        ST_MATCH    = 3'b101,
        ST_GAMEOVER = 3'b110
    } state_t;

    // Round verdict encoding
    localparam logic [1:0] MR_NONE = 2'b00;
    localparam logic [1:0] MR_DRAW = 2'b01;
    localparam logic [1:0] MR_P1   = 2'b10;
    localparam logic [1:0] MR_P2   = 2'b11;

    // Game verdict encoding
    localparam logic [1:0] GR_NONE = 2'b00;
    localparam logic [1:0] GR_DRAW = 2'b01;
    localparam logic [1:0] GR_P1   = 2'b10;
    localparam logic [1:0] GR_P2   = 2'b11;

    // Tiles are 0..8: five even (black) and four odd (white) per player
    localparam logic [3:0] TILE_MAX   = 4'd8;
    localparam int         TILE_SLOTS = 9;
    localparam logic [3:0] BLACK_INIT = 4'd5;
    localparam logic [3:0] WHITE_INIT = 4'd4;

endpackage

// File: rtl/bw_game_ctrl_if.sv
// Input/status bus between the button/switch front end and the game controller.
// master: drives start/confirm/card_sel and reads status (front end / bench).
// slave : the controller, consuming inputs and driving every status field.
interface bw_game_ctrl_if;
    import bw_game_ctrl_pkg::*;

    logic       start;
    logic       confirm;
    logic [3:0] card_sel;
    logic [2:0] state;
    logic [3:0] round;
    logic [3:0] win;
    logic [3:0] lose;
    logic [3:0] p1_black;
    logic [3:0] p1_white;
    logic [3:0] p2_black;
    logic [3:0] p2_white;
    logic [1:0] matchresult;
    logic [1:0] gameresult;
    logic       card_err;

    modport master (
        output start, confirm, card_sel,
        input  state, round, win, lose, p1_black, p1_white, p2_black, p2_white,
               matchresult, gameresult, card_err
    );

    modport slave (
        input  start, confirm, card_sel,
        output state, round, win, lose, p1_black, p1_white, p2_black, p2_white,
               matchresult, gameresult, card_err
    );

endinterface

// File: rtl/bw_tile_bank.sv
// One player's tile bank: 9-bit used mask plus remaining black/white counts.
// Ports: clk/reset; clear_i reloads a full bank; commit_i consumes tile_i if valid;
// valid_o = tile in range and unused (combinational); black_o/white_o = remaining.
module bw_tile_bank
    import bw_game_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       commit_i,
    input  logic [3:0] tile_i,
    output logic       valid_o,
    output logic [3:0] black_o,
    output logic [3:0] white_o
);

    logic [TILE_SLOTS-1:0] used_q, used_d;
    logic [3:0]            black_q, white_q;
    logic                  used_hit;

    // Decode the tile with a loop so out-of-range values simply match nothing
    always_comb begin
        used_hit = 1'b0;
        used_d   = used_q;
        for (int i = 0; i < TILE_SLOTS; i++) begin
            if (tile_i == 4'(i)) begin
                used_hit  = used_q[i];
                used_d[i] = 1'b1;
            end
        end
    end

    assign valid_o = (tile_i <= TILE_MAX) && !used_hit;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            used_q  <= '0;
            black_q <= BLACK_INIT;
            white_q <= WHITE_INIT;
        end else if (commit_i && valid_o) begin
            used_q <= used_d;
            // An unused tile guarantees its colour count is non-zero
            if (tile_i[0]) white_q <= white_q - 4'd1;
            else           black_q <= black_q - 4'd1;
        end
    end

    assign black_o = black_q;
    assign white_o = white_q;

endmodule

// File: rtl/bw_game_ctrl.sv
// Sequencing controller for the black-and-white tile game: state machine,
// round/score counters, per-player tile banks and round/game verdicts.
// Ports: clk, reset (sync, active-high), bus (slave modport: start/confirm/card_sel in, status out).
module bw_game_ctrl
    import bw_game_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000000,
    parameter int WIN_TARGET   = 5,
    parameter int NUM_ROUNDS   = 9
)(
    input  logic           clk,
    input  logic           reset,
    bw_game_ctrl_if.slave  bus
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    round_q, round_d;
    logic [3:0]    win_q, win_d;
    logic [3:0]    lose_q, lose_d;
    logic [1:0]    mr_q, mr_d;
    logic [1:0]    gr_q, gr_d;
    logic          err_q, err_d;
    logic          leader_q, leader_d;      // 0 = P1 leads, 1 = P2 leads
    logic [3:0]    p1_tile_q, p1_tile_d;
    logic [3:0]    p2_tile_q, p2_tile_d;

    logic          p1_valid, p2_valid;
    logic          p1_commit, p2_commit;
    logic          bank_clr;
    logic          enter_match;
    logic          dwell_state, dwell_done;
    logic [3:0]    cmp_p1, cmp_p2;

    bw_tile_bank u_p1_bank (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (bank_clr),
        .commit_i (p1_commit),
        .tile_i   (bus.card_sel),
        .valid_o  (p1_valid),
        .black_o  (bus.p1_black),
        .white_o  (bus.p1_white)
    );

    bw_tile_bank u_p2_bank (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (bank_clr),
        .commit_i (p2_commit),
        .tile_i   (bus.card_sel),
        .valid_o  (p2_valid),
        .black_o  (bus.p2_black),
        .white_o  (bus.p2_white)
    );

    assign dwell_state = (state_q == ST_RASP) || (state_q == ST_BAWP) || (state_q == ST_MATCH);
    assign dwell_done  = (dwell_q == DW'(DWELL_CYCLES - 1));

    // The follower's tile is registered on the same edge that enters MATCH,
    // so the comparison takes it straight from the switches.
    assign cmp_p1 = (state_q == ST_P1_TURN) ? bus.card_sel : p1_tile_q;
    assign cmp_p2 = (state_q == ST_P2_TURN) ? bus.card_sel : p2_tile_q;

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        win_d       = win_q;
        lose_d      = lose_q;
        mr_d        = mr_q;
        gr_d        = gr_q;
        err_d       = 1'b0;
        leader_d    = leader_q;
        p1_tile_d   = p1_tile_q;
        p2_tile_d   = p2_tile_q;
        p1_commit   = 1'b0;
        p2_commit   = 1'b0;
        bank_clr    = 1'b0;
        enter_match = 1'b0;

        case (state_q)
            ST_INIT, ST_GAMEOVER: begin
                if (bus.start) begin
                    state_d   = ST_RASP;
                    round_d   = 4'd1;
                    win_d     = 4'd0;
                    lose_d    = 4'd0;
                    mr_d      = MR_NONE;
                    gr_d      = GR_NONE;
                    leader_d  = 1'b0;
                    p1_tile_d = 4'd0;
                    p2_tile_d = 4'd0;
                    bank_clr  = 1'b1;
                end
            end
            ST_RASP: begin
                if (dwell_done) state_d = leader_q ? ST_P2_TURN : ST_P1_TURN;
            end
            ST_BAWP: begin
                if (dwell_done) state_d = leader_q ? ST_P1_TURN : ST_P2_TURN;
            end
            ST_P1_TURN: begin
                if (bus.confirm) begin
                    if (p1_valid) begin
                        p1_commit = 1'b1;
                        p1_tile_d = bus.card_sel;
                        if (!leader_q) state_d = ST_BAWP;
                        else begin
                            state_d     = ST_MATCH;
                            enter_match = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_P2_TURN: begin
                if (bus.confirm) begin
                    if (p2_valid) begin
                        p2_commit = 1'b1;
                        p2_tile_d = bus.card_sel;
                        if (leader_q) state_d = ST_BAWP;
                        else begin
                            state_d     = ST_MATCH;
                            enter_match = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_MATCH: begin
                if (dwell_done) begin
                    if (win_q == 4'(WIN_TARGET) || lose_q == 4'(WIN_TARGET) ||
                        round_q == 4'(NUM_ROUNDS)) begin
                        state_d = ST_GAMEOVER;
                        if (win_q > lose_q)      gr_d = GR_P1;
                        else if (lose_q > win_q) gr_d = GR_P2;
                        else                     gr_d = GR_DRAW;
                    end else begin
                        state_d = ST_RASP;
                        mr_d    = MR_NONE;
                        if (round_q < 4'(NUM_ROUNDS)) round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Round verdict; a draw leaves the leader where it was
        if (enter_match) begin
            if (cmp_p1 > cmp_p2) begin
                mr_d     = MR_P1;
                leader_d = 1'b0;
                if (win_q < 4'(WIN_TARGET)) win_d = win_q + 4'd1;
            end else if (cmp_p2 > cmp_p1) begin
                mr_d     = MR_P2;
                leader_d = 1'b1;
                if (lose_q < 4'(WIN_TARGET)) lose_d = lose_q + 4'd1;
            end else begin
                mr_d = MR_DRAW;
            end
        end

        dwell_d = (dwell_state && state_d == state_q) ? dwell_q + DW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_INIT;
            dwell_q   <= '0;
            round_q   <= 4'd1;
            win_q     <= 4'd0;
            lose_q    <= 4'd0;
            mr_q      <= MR_NONE;
            gr_q      <= GR_NONE;
            err_q     <= 1'b0;
            leader_q  <= 1'b0;
            p1_tile_q <= 4'd0;
            p2_tile_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            round_q   <= round_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            mr_q      <= mr_d;
            gr_q      <= gr_d;
            err_q     <= err_d;
            leader_q  <= leader_d;
            p1_tile_q <= p1_tile_d;
            p2_tile_q <= p2_tile_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.round       = round_q;
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;
    assign bus.matchresult = mr_q;
    assign bus.gameresult  = gr_q;
    assign bus.card_err    = err_q;

endmodule

// File: tb/tb_bw_game_ctrl.sv
// Directed bench for bw_game_ctrl with DWELL_CYCLES=4.
// Stimulus pushes hand-computed expected snapshots into a queue; a monitor
// pops and compares one snapshot after each clock edge that has one pending.
module tb_bw_game_ctrl;
    import bw_game_ctrl_pkg::*;

    localparam int DW = 4;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] rnd;
        logic [3:0] win;
        logic [3:0] lose;
        logic [3:0] p1b;
        logic [3:0] p1w;
        logic [3:0] p2b;
        logic [3:0] p2w;
        logic [1:0] mr;
        logic [1:0] gr;
        logic       err;
    } snap_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    snap_t e;
    snap_t exp_q[$];
    string name_q[$];
    snap_t mx, mg;
    string mn;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    bw_game_ctrl_if bus();

    bw_game_ctrl #(
        .DWELL_CYCLES (DW),
        .WIN_TARGET   (5),
        .NUM_ROUNDS   (9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Monitor: compare one pending expectation just after each rising edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mx = exp_q.pop_front();
            mn = name_q.pop_front();
            mg.st   = bus.state;
            mg.rnd  = bus.round;
            mg.win  = bus.win;
            mg.lose = bus.lose;
            mg.p1b  = bus.p1_black;
            mg.p1w  = bus.p1_white;
            mg.p2b  = bus.p2_black;
            mg.p2w  = bus.p2_white;
            mg.mr   = bus.matchresult;
            mg.gr   = bus.gameresult;
            mg.err  = bus.card_err;
            checks++;
            if (mg !== mx) begin
                errors++;
                $display("FAIL %s got st=%0d rnd=%0d w=%0d l=%0d p1=%0d/%0d p2=%0d/%0d mr=%b gr=%b err=%b | exp st=%0d rnd=%0d w=%0d l=%0d p1=%0d/%0d p2=%0d/%0d mr=%b gr=%b err=%b",
                         mn, mg.st, mg.rnd, mg.win, mg.lose, mg.p1b, mg.p1w, mg.p2b, mg.p2w, mg.mr, mg.gr, mg.err,
                         mx.st, mx.rnd, mx.win, mx.lose, mx.p1b, mx.p1w, mx.p2b, mx.p2w, mx.mr, mx.gr, mx.err);
            end
        end
    end

    function automatic snap_t rst_snap();
        snap_t s;
        s.st = ST_INIT; s.rnd = 4'd1; s.win = 4'd0; s.lose = 4'd0;
        s.p1b = 4'd5; s.p1w = 4'd4; s.p2b = 4'd5; s.p2w = 4'd4;
        s.mr = 2'b00; s.gr = 2'b00; s.err = 1'b0;
        return s;
    endfunction

    // Drive inputs for one clock; optionally queue the expected post-edge snapshot
    task automatic step(input logic r, input logic s, input logic c, input logic [3:0] card,
                        input bit chk, input string nm);
        reset        = r;
        bus.start    = s;
        bus.confirm  = c;
        bus.card_sel = card;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(negedge clk);
        bus.start   = 1'b0;
        bus.confirm = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "");
    endtask

    task automatic play(input logic [3:0] card, input string nm);
        step(1'b0, 1'b0, 1'b1, card, 1'b1, nm);
    endtask

    // Current dwell state must hold through its last cycle, then move to nxt
    task automatic dwell_to(input state_t nxt, input string nm);
        idle(DW - 2);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, {nm, "_hold"});
        e.st = nxt;
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, nm);
    endtask

    // MATCH dwell -> RASP (next round) -> RASP dwell -> leader's turn
    task automatic next_round(input state_t turn, input string nm);
        idle(DW - 2);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, {nm, "_match_hold"});
        e.rnd = e.rnd + 4'd1;
        e.mr  = 2'b00;
        e.st  = ST_RASP;
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, {nm, "_to_rasp"});
        dwell_to(turn, {nm, "_to_turn"});
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.confirm  = 1'b0;
        bus.card_sel = 4'd0;
        e = rst_snap();
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "reset");

        e.st = ST_RASP;
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, "start");
        step(1'b0, 1'b0, 1'b1, 4'd6, 1'b1, "rasp_confirm_ignored");
        idle(1);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "rasp_hold");
        e.st = ST_P1_TURN;
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "rasp_exit_p1");
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, "turn_start_ignored");

        // Round 1: P1 6 beats P2 3
        e.p1b = 4'd4; e.st = ST_BAWP;
        play(4'd6, "r1_p1_6");
        dwell_to(ST_P2_TURN, "r1_bawp");
        e.p2w = 4'd3; e.st = ST_MATCH; e.mr = 2'b10; e.win = 4'd1;
        play(4'd3, "r1_p2_3");
        next_round(ST_P1_TURN, "r1");

        // Rejected confirms
        e.err = 1'b1; play(4'd6, "used_tile");
        e.err = 1'b0; step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "err_clear");
        e.err = 1'b1; play(4'd9, "tile9");
        e.err = 1'b0; step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "err_clear2");

        // Round 2: draw 4/4, leader stays P1
        e.p1b = 4'd3; e.st = ST_BAWP; play(4'd4, "r2_p1_4");
        dwell_to(ST_P2_TURN, "r2_bawp");
        e.p2b = 4'd4; e.st = ST_MATCH; e.mr = 2'b01; play(4'd4, "r2_draw");
        next_round(ST_P1_TURN, "r2");

        // Round 3: P1 0, P2 1 -> P2 wins and leads
        e.p1b = 4'd2; e.st = ST_BAWP; play(4'd0, "r3_p1_0");
        dwell_to(ST_P2_TURN, "r3_bawp");
        e.p2w = 4'd2; e.st = ST_MATCH; e.mr = 2'b11; e.lose = 4'd1; play(4'd1, "r3_p2_1");
        next_round(ST_P2_TURN, "r3");

        // Round 4: P2 2, P1 1
        e.p2b = 4'd3; e.st = ST_BAWP; play(4'd2, "r4_p2_2");
        dwell_to(ST_P1_TURN, "r4_bawp");
        e.p1w = 4'd3; e.st = ST_MATCH; e.mr = 2'b11; e.lose = 4'd2; play(4'd1, "r4_p1_1");
        next_round(ST_P2_TURN, "r4");

        // Round 5: P2 5, P1 2
        e.p2w = 4'd1; e.st = ST_BAWP; play(4'd5, "r5_p2_5");
        dwell_to(ST_P1_TURN, "r5_bawp");
        e.p1b = 4'd1; e.st = ST_MATCH; e.mr = 2'b11; e.lose = 4'd3; play(4'd2, "r5_p1_2");
        next_round(ST_P2_TURN, "r5");

        // Round 6: P2 6, P1 3
        e.p2b = 4'd2; e.st = ST_BAWP; play(4'd6, "r6_p2_6");
        dwell_to(ST_P1_TURN, "r6_bawp");
        e.p1w = 4'd2; e.st = ST_MATCH; e.mr = 2'b11; e.lose = 4'd4; play(4'd3, "r6_p1_3");
        next_round(ST_P2_TURN, "r6");

        // Round 7: P2 7, P1 5 -> fifth P2 win ends the game
        e.p2w = 4'd0; e.st = ST_BAWP; play(4'd7, "r7_p2_7");
        dwell_to(ST_P1_TURN, "r7_bawp");
        e.p1w = 4'd1; e.st = ST_MATCH; e.mr = 2'b11; e.lose = 4'd5; play(4'd5, "r7_p1_5");
        idle(DW - 2);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "r7_match_hold");
        e.st = ST_GAMEOVER; e.gr = 2'b11;
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "gameover_p2");
        step(1'b0, 1'b0, 1'b1, 4'd8, 1'b1, "gameover_confirm_ignored");

        // Restart from GAMEOVER reloads everything
        e = rst_snap(); e.st = ST_RASP;
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, "restart");
        dwell_to(ST_P1_TURN, "restart_rasp");

        // Reset with confirm mid-BAWP
        e.p1b = 4'd4; e.st = ST_BAWP; play(4'd8, "g2_p1_8");
        idle(1);
        e = rst_snap();
        step(1'b1, 1'b0, 1'b1, 4'd7, 1'b1, "reset_mid_bawp");
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "post_reset_init");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
